fifo_line_buf_seq: RTL and testbench
====================================

Name: fifo_line_buf_seq

Overview:
- Single-clock sequencer for a synchronous ("SYN") line-buffer FIFO, used as a one-line delay in the video pipeline.
- Writes each incoming line into the FIFO and reads it back while the next line arrives.
- Presents every pixel together with the pixel directly above it (same column, previous line).
- Handles the first line of a frame (fill), end-of-frame drain, and error recovery by pulsing the FIFO reset.

Parameters:
- c_DATA_WIDTH, 16: pixel width.
- c_DEPTH_WIDTH, 11: FIFO address width; maximum line length is 2^c_DEPTH_WIDTH pixels.
- c_RD_LAT, 1: FIFO read-data latency in clocks. Legal values are 1 (no output register) and 2 (output register).
- c_CLR_CYCLES, 2: length of the fifo_rst pulse in the CLEAR state, in clocks.

Ports:
- clk  in  1  single clock for all logic and the FIFO (wr_clk = rd_clk = clk).
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel; a pixel is accepted when in_valid & in_ready.
- in_data  in  c_DATA_WIDTH  input pixel.
- in_sof  in  1  first pixel of frame.
- in_eol  in  1  last pixel of line.
- in_eof  in  1  last pixel of frame; only meaningful together with in_eol.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  c_DATA_WIDTH  FIFO write data (equals in_data).
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rd_data  in  c_DATA_WIDTH  FIFO read data.
- fifo_wr_full  in  1  FIFO full.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_rst  out  1  FIFO reset, registered, drives both FIFO wr_rst and rd_rst.
- out_valid  out  1  output pixel valid.
- out_cur  out  c_DATA_WIDTH  current pixel.
- out_prev  out  c_DATA_WIDTH  pixel above; forced to 0 when out_prev_vld = 0.
- out_prev_vld  out  1  out_prev is real data (0 on the first line of a frame).
- out_sof, out_eol, out_eof  out  1 each  input flags, delayed to align with out_cur.
- line_len  out  c_DEPTH_WIDTH+1  length of the first line of the current frame.
- err_len  out  1  sticky: line-length mismatch.
- err_ovf  out  1  sticky: FIFO full while filling.
- err_unf  out  1  sticky: read needed while FIFO empty.
- busy  out  1  state != IDLE.

Behaviour:
Reset values:
- All outputs 0, except in_ready = 1.
- State = IDLE; column counter = 0.
- Sticky error flags clear only on rst.

States:
- IDLE
  - in_ready = 1.
  - Accepted pixels without in_sof are dropped (no write, no output).
  - Accepted pixel with in_sof: write it, col = 1, go to FILL.
  - sof & eol on the same pixel (1-pixel line): line_len = 1, go to STREAM.
- FILL
  - Every accepted pixel: fifo_wr_en = 1, col increments, output with out_prev_vld = 0.
  - If fifo_wr_full is high when a pixel is accepted: set err_ovf, suppress the write, go to CLEAR.
  - On in_eol: line_len = col+1 (count includes the eol pixel), col = 0.
    - With in_eof (single-line frame): go to DRAIN.
    - Otherwise: go to STREAM.
- STREAM
  - Every accepted pixel: fifo_wr_en = 1 and fifo_rd_en = 1 in the same cycle; col increments.
  - If fifo_rd_empty is high when a read is due: set err_unf, suppress rd_en, go to CLEAR.
  - Length check: in_eol with col+1 != line_len, or col+1 reaching line_len without in_eol, sets err_len and goes to CLEAR (that pixel is still output).
  - Correct in_eol: col = 0; with in_eof, go to DRAIN.
  - in_sof in STREAM is treated as a length error.
- DRAIN
  - in_ready = 0.
  - fifo_rd_en = !fifo_rd_empty each cycle; read data is discarded and out_valid stays 0.
  - Go to IDLE on the first cycle in which fifo_rd_empty = 1 and no read is pending.
- CLEAR
  - in_ready = 0; fifo_rst = 1 for c_CLR_CYCLES clocks.
  - Then one further idle clock, then IDLE.
  - In-flight output pipeline entries are invalidated.

Alignment and latency:
- out_cur, out_sof/out_eol/out_eof and out_prev_vld pass through a c_RD_LAT-stage register pipeline.
- out_prev = fifo_rd_data, gated by the aligned out_prev_vld.
- out_valid is asserted exactly c_RD_LAT clocks after acceptance.
- No bubbles are inserted; throughput is 1 pixel per clock in FILL and STREAM.

Other rules:
- col saturates at 2^c_DEPTH_WIDTH. A FILL line longer than the FIFO hits fifo_wr_full, giving err_ovf.
- fifo_wr_en and fifo_rd_en are combinational from acceptance and state; all other outputs are registered.
- rst asserted mid-line: immediate return to IDLE, and all pipeline stages are cleared.

Test Plan:
- 3-line frame, line length 4, c_RD_LAT = 1, in_valid held high:
  - Line 0 gives 4 outputs with out_prev_vld = 0.
  - Lines 1–2 give out_prev equal to the previous line's pixels, 1 clock after acceptance.
  - After eof, DRAIN issues 4 reads; busy falls; line_len = 4.
- Same frame with c_RD_LAT = 2 and random in_valid gaps: out_cur/out_prev pairs are identical to the previous case, each 2 clocks after its acceptance.
- Line 1 ends after 3 pixels (line_len = 4): err_len = 1; fifo_rst is high for 2 clocks; in_ready = 0 during CLEAR; the next sof frame processes cleanly.
- c_DEPTH_WIDTH = 3, first line of 9 pixels: err_ovf = 1 on pixel 9, no write for that pixel, CLEAR entered.
- Force fifo_rd_empty = 1 at the first STREAM pixel: err_unf = 1, fifo_rd_en stays 0, CLEAR entered.
- Assert rst mid-line 1: all outputs return to reset values at once; a following frame yields out_prev_vld = 0 on its first line.

Source files
------------

// File: rtl/fifo_line_buf_seq.sv
// Line-buffer sequencer: writes each line into an external synchronous FIFO and reads it back
// one line later, so every output pixel is paired with the pixel directly above it.
module fifo_line_buf_seq #(
    parameter int c_DATA_WIDTH  = 16,
    parameter int c_DEPTH_WIDTH = 11,
    parameter int c_RD_LAT      = 1,
    parameter int c_CLR_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [c_DATA_WIDTH-1:0]  in_data,
    input  logic                     in_sof,
    input  logic                     in_eol,
    input  logic                     in_eof,
    output logic                     fifo_wr_en,
    output logic [c_DATA_WIDTH-1:0]  fifo_wr_data,
    output logic                     fifo_rd_en,
    input  logic [c_DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                     fifo_wr_full,
    input  logic                     fifo_rd_empty,
    output logic                     fifo_rst,
    output logic                     out_valid,
    output logic [c_DATA_WIDTH-1:0]  out_cur,
    output logic [c_DATA_WIDTH-1:0]  out_prev,
    output logic                     out_prev_vld,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     out_eof,
    output logic [c_DEPTH_WIDTH:0]   line_len,
    output logic                     err_len,
    output logic                     err_ovf,
    output logic                     err_unf,
    output logic                     busy
);
    localparam int CW   = c_DEPTH_WIDTH + 1;
    localparam int CLRW = $clog2(c_CLR_CYCLES + 1);
    localparam logic [CW-1:0]   COL_MAX = {1'b1, {c_DEPTH_WIDTH{1'b0}}};
    localparam logic [CLRW-1:0] CLR_N   = CLRW'(c_CLR_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_DRAIN, S_CLEAR} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d, col_inc, line_len_q, line_len_d;
    logic [CLRW-1:0]     clr_cnt_q, clr_cnt_d;
    logic                err_len_q, err_len_d, err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
    logic                in_ready_q, busy_q, fifo_rst_q;
    logic [c_RD_LAT-1:0] pend_q;
    logic                acc, push, push_pv, flush;

    logic [c_RD_LAT-1:0]     vld_q, pv_q, sof_q, eol_q, eof_q;
    logic [c_DATA_WIDTH-1:0] cur_q [c_RD_LAT];

    assign acc     = in_valid & in_ready_q;
    assign col_inc = (col_q == COL_MAX) ? COL_MAX : col_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        line_len_d = line_len_q;
        clr_cnt_d  = '0;
        err_len_d  = err_len_q;
        err_ovf_d  = err_ovf_q;
        err_unf_d  = err_unf_q;
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        push       = 1'b0;
        push_pv    = 1'b0;
        flush      = 1'b0;
        case (state_q)
            S_IDLE: if (acc && in_sof) begin
                fifo_wr_en = 1'b1;
                push       = 1'b1;
                if (in_eol) begin
                    line_len_d = CW'(1);
                    col_d      = '0;
                    state_d    = in_eof ? S_DRAIN : S_STREAM;
                end else begin
                    col_d   = CW'(1);
                    state_d = S_FILL;
                end
            end
            S_FILL: if (acc) begin
                // An overflowing pixel is neither written nor shown; the whole pipeline is dropped.
                if (fifo_wr_full) begin
                    err_ovf_d = 1'b1;
                    flush     = 1'b1;
                    state_d   = S_CLEAR;
                end else begin
                    fifo_wr_en = 1'b1;
                    push       = 1'b1;
                    if (in_eol) begin
                        line_len_d = col_inc;
                        col_d      = '0;
                        state_d    = in_eof ? S_DRAIN : S_STREAM;
                    end else begin
                        col_d = col_inc;
                    end
                end
            end
            S_STREAM: if (acc) begin
                if (fifo_rd_empty) begin
                    err_unf_d = 1'b1;
                    flush     = 1'b1;
                    state_d   = S_CLEAR;
                end else begin
                    fifo_wr_en = 1'b1;
                    fifo_rd_en = 1'b1;
                    push       = 1'b1;
                    push_pv    = 1'b1;
                    // eol must coincide exactly with reaching the first line's length.
                    if (in_sof || (in_eol != (col_inc == line_len_q))) begin
                        err_len_d = 1'b1;
                        col_d     = '0;
                        state_d   = S_CLEAR;
                    end else if (in_eol) begin
                        col_d   = '0;
                        state_d = in_eof ? S_DRAIN : S_STREAM;
                    end else begin
                        col_d = col_inc;
                    end
                end
            end
            S_DRAIN: begin
                fifo_rd_en = !fifo_rd_empty;
                if (fifo_rd_empty && (pend_q == '0)) state_d = S_IDLE;
            end
            S_CLEAR: begin
                col_d = '0;
                if (clr_cnt_q == CLR_N) state_d = S_IDLE;
                else                    clr_cnt_d = clr_cnt_q + CLRW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            line_len_q <= '0;
            clr_cnt_q  <= '0;
            err_len_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            fifo_rst_q <= 1'b0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            line_len_q <= line_len_d;
            clr_cnt_q  <= clr_cnt_d;
            err_len_q  <= err_len_d;
            err_ovf_q  <= err_ovf_d;
            err_unf_q  <= err_unf_d;
            in_ready_q <= (state_d == S_IDLE) || (state_d == S_FILL) || (state_d == S_STREAM);
            busy_q     <= (state_d != S_IDLE);
            fifo_rst_q <= (state_d == S_CLEAR) && (clr_cnt_d < CLR_N);
            pend_q     <= (pend_q << 1) | c_RD_LAT'(fifo_rd_en);
        end
    end

    // Output pipeline: c_RD_LAT stages so out_cur lines up with fifo_rd_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            pv_q  <= '0;
            sof_q <= '0;
            eol_q <= '0;
            eof_q <= '0;
            for (int i = 0; i < c_RD_LAT; i++) cur_q[i] <= '0;
        end else begin
            vld_q <= flush ? '0 : ((vld_q << 1) | c_RD_LAT'(push));
            pv_q  <= flush ? '0 : ((pv_q << 1) | c_RD_LAT'(push_pv));
            sof_q <= (sof_q << 1) | c_RD_LAT'(push & in_sof);
            eol_q <= (eol_q << 1) | c_RD_LAT'(push & in_eol);
            eof_q <= (eof_q << 1) | c_RD_LAT'(push & in_eof);
            for (int i = c_RD_LAT - 1; i > 0; i--) cur_q[i] <= cur_q[i-1];
            cur_q[0] <= in_data;
        end
    end

    assign in_ready     = in_ready_q;
    assign fifo_wr_data = in_data;
    assign fifo_rst     = fifo_rst_q;
    assign out_valid    = vld_q[c_RD_LAT-1];
    assign out_cur      = cur_q[c_RD_LAT-1];
    assign out_prev_vld = pv_q[c_RD_LAT-1];
    assign out_prev     = pv_q[c_RD_LAT-1] ? fifo_rd_data : '0;
    assign out_sof      = sof_q[c_RD_LAT-1];
    assign out_eol      = eol_q[c_RD_LAT-1];
    assign out_eof      = eof_q[c_RD_LAT-1];
    assign line_len     = line_len_q;
    assign err_len      = err_len_q;
    assign err_ovf      = err_ovf_q;
    assign err_unf      = err_unf_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_fifo_line_buf_seq.sv
// Directed bench: two sequencer instances (read latency 1 / depth 2048, read latency 2 / depth 8)
// each attached to a small behavioural synchronous FIFO.
module tb_fifo_line_buf_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance 1: c_RD_LAT = 1, c_DEPTH_WIDTH = 11
    logic        v1 = 0, sof1 = 0, eol1 = 0, eof1 = 0, force_empty = 0;
    logic [15:0] data1 = 0;
    logic        rdy1, wr1, rd1, full1, empty1, frst1, ov1, pv1, osof1, oeol1, oeof1;
    logic        el1, eo1, eu1, busy1;
    logic [15:0] wd1, rdd1, cur1, prev1;
    logic [11:0] ll1;

    fifo_line_buf_seq #(.c_DATA_WIDTH(16), .c_DEPTH_WIDTH(11), .c_RD_LAT(1), .c_CLR_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(data1),
        .in_sof(sof1), .in_eol(eol1), .in_eof(eof1),
        .fifo_wr_en(wr1), .fifo_wr_data(wd1), .fifo_rd_en(rd1), .fifo_rd_data(rdd1),
        .fifo_wr_full(full1), .fifo_rd_empty(empty1), .fifo_rst(frst1),
        .out_valid(ov1), .out_cur(cur1), .out_prev(prev1), .out_prev_vld(pv1),
        .out_sof(osof1), .out_eol(oeol1), .out_eof(oeof1), .line_len(ll1),
        .err_len(el1), .err_ovf(eo1), .err_unf(eu1), .busy(busy1));

    logic [15:0] mem1 [2048];
    int wp1 = 0, rp1 = 0, cnt1 = 0;
    assign full1  = (cnt1 == 2048);
    assign empty1 = (cnt1 == 0) || force_empty;
    always @(posedge clk) begin
        if (rst || frst1) begin
            wp1 <= 0; rp1 <= 0; cnt1 <= 0; rdd1 <= '0;
        end else begin
            if (rd1) begin rdd1 <= mem1[rp1]; rp1 <= (rp1 + 1) % 2048; end
            if (wr1) begin mem1[wp1] <= wd1; wp1 <= (wp1 + 1) % 2048; end
            cnt1 <= cnt1 + (wr1 ? 1 : 0) - (rd1 ? 1 : 0);
        end
    end

    // ---------------- instance 2: c_RD_LAT = 2, c_DEPTH_WIDTH = 3
    logic        v2 = 0, sof2 = 0, eol2 = 0, eof2 = 0;
    logic [15:0] data2 = 0;
    logic        rdy2, wr2, rd2, full2, empty2, frst2, ov2, pv2, osof2, oeol2, oeof2;
    logic        el2, eo2, eu2, busy2;
    logic [15:0] wd2, rdd2, rdd2a, cur2, prev2;
    logic [3:0]  ll2;

    fifo_line_buf_seq #(.c_DATA_WIDTH(16), .c_DEPTH_WIDTH(3), .c_RD_LAT(2), .c_CLR_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(data2),
        .in_sof(sof2), .in_eol(eol2), .in_eof(eof2),
        .fifo_wr_en(wr2), .fifo_wr_data(wd2), .fifo_rd_en(rd2), .fifo_rd_data(rdd2),
        .fifo_wr_full(full2), .fifo_rd_empty(empty2), .fifo_rst(frst2),
        .out_valid(ov2), .out_cur(cur2), .out_prev(prev2), .out_prev_vld(pv2),
        .out_sof(osof2), .out_eol(oeol2), .out_eof(oeof2), .line_len(ll2),
        .err_len(el2), .err_ovf(eo2), .err_unf(eu2), .busy(busy2));

    logic [15:0] mem2 [8];
    int wp2 = 0, rp2 = 0, cnt2 = 0;
    assign full2  = (cnt2 == 8);
    assign empty2 = (cnt2 == 0);
    always @(posedge clk) begin
        if (rst || frst2) begin
            wp2 <= 0; rp2 <= 0; cnt2 <= 0; rdd2a <= '0; rdd2 <= '0;
        end else begin
            if (rd2) begin rdd2a <= mem2[rp2]; rp2 <= (rp2 + 1) % 8; end
            rdd2 <= rdd2a;
            if (wr2) begin mem2[wp2] <= wd2; wp2 <= (wp2 + 1) % 8; end
            cnt2 <= cnt2 + (wr2 ? 1 : 0) - (rd2 ? 1 : 0);
        end
    end

    // Output monitor for instance 2 (records each output and the cycle it appeared in)
    logic [15:0] m_cur[$], m_prev[$];
    logic        m_pv[$];
    int          m_cyc[$];
    always @(negedge clk) if (ov2) begin
        m_cur.push_back(cur2); m_prev.push_back(prev2); m_pv.push_back(pv2); m_cyc.push_back(cyc);
    end

    task automatic drv1(input logic v, input logic [15:0] d, input logic s, input logic e, input logic f);
        v1 = v; data1 = d; sof1 = s; eol1 = e; eof1 = f;
    endtask

    task automatic send1(input logic [15:0] d, input logic s, input logic e, input logic f);
        drv1(1'b1, d, s, e, f);
        @(posedge clk); #1;
    endtask

    task automatic wait_ready1(input string name);
        int n = 0;
        while (!rdy1 && n < 30) begin @(posedge clk); #1; n++; end
        checks++;
        if (!rdy1) begin errors++; $display("FAIL %s: in_ready still %0b after %0d cycles, need 1", name, rdy1, n); end
    endtask

    // Sends a frame into instance 1 with in_valid held high and checks every output, then the drain.
    task automatic run_frame1(input int nl, input int len, input logic [15:0] base);
        logic [15:0] exp_cur, exp_prev;
        int reads = 0, stray = 0, n;
        bit done = 0;
        for (int l = 0; l < nl; l++) begin
            for (int c = 0; c < len; c++) begin
                exp_cur  = base + 16'(l * 16 + c);
                exp_prev = (l > 0) ? base + 16'((l - 1) * 16 + c) : 16'h0;
                drv1(1'b1, exp_cur, l == 0 && c == 0, c == len - 1, l == nl - 1 && c == len - 1);
                #1;
                checks++;
                if (wr1 !== 1'b1 || rd1 !== (l > 0)) begin
                    errors++; $display("FAIL strobes l%0d c%0d: wr=%0b rd=%0b, need wr=1 rd=%0b", l, c, wr1, rd1, l > 0);
                end
                @(posedge clk); #1;
                checks++;
                if (ov1 !== 1'b1 || cur1 !== exp_cur) begin
                    errors++; $display("FAIL out_cur l%0d c%0d: valid=%0b cur=%h, need 1 %h", l, c, ov1, cur1, exp_cur);
                end
                checks++;
                if (pv1 !== (l > 0) || prev1 !== exp_prev) begin
                    errors++; $display("FAIL out_prev l%0d c%0d: pv=%0b prev=%h, need %0b %h", l, c, pv1, prev1, l > 0, exp_prev);
                end
                checks++;
                if (osof1 !== (l == 0 && c == 0) || oeol1 !== (c == len - 1) || oeof1 !== (l == nl - 1 && c == len - 1)) begin
                    errors++; $display("FAIL flags l%0d c%0d: sof/eol/eof=%0b%0b%0b", l, c, osof1, oeol1, oeof1);
                end
            end
        end
        drv1(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rdy1 !== 1'b0) begin errors++; $display("FAIL drain_ready: in_ready=%0b, need 0", rdy1); end
        for (n = 0; n < 40; n++) begin
            if (n > 0 && ov1) stray++;
            if (rd1) reads++;
            if (!busy1) begin done = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL drain_timeout: busy=%0b after %0d cycles, need 0", busy1, n); end
        checks++;
        if (reads != len) begin errors++; $display("FAIL drain_reads: %0d reads, need %0d", reads, len); end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL drain_valid: %0d outputs during drain, need 0", stray); end
        checks++;
        if (ll1 !== 12'(len)) begin errors++; $display("FAIL line_len: %0d, need %0d", ll1, len); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin errors++; $display("FAIL reset_ready: %0b %0b, need 1 1", rdy1, rdy2); end
        checks++;
        if ({ov1, busy1, frst1, el1, eo1, eu1, pv1, oeol1} !== 8'h0 || cur1 !== 16'h0 || ll1 !== 12'h0) begin
            errors++; $display("FAIL reset_outputs: ctl=%b cur=%h len=%0d, need all 0", {ov1, busy1, frst1, el1, eo1, eu1, pv1, oeol1}, cur1, ll1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_frame;
        run_frame1(3, 4, 16'h0100);
    endtask

    task automatic test_len_err;
        int nf = 0, nw = 0;
        for (int c = 0; c < 4; c++) send1(16'h0200 + 16'(c), c == 0, c == 3, 1'b0);
        send1(16'h0210, 1'b0, 1'b0, 1'b0);
        send1(16'h0211, 1'b0, 1'b0, 1'b0);
        send1(16'h0212, 1'b0, 1'b1, 1'b0);
        drv1(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (el1 !== 1'b1) begin errors++; $display("FAIL err_len: %0b, need 1", el1); end
        checks++;
        if (ov1 !== 1'b1 || cur1 !== 16'h0212 || prev1 !== 16'h0202) begin
            errors++; $display("FAIL len_err_pixel: valid=%0b cur=%h prev=%h, need 1 0212 0202", ov1, cur1, prev1);
        end
        while (!rdy1 && nw < 20) begin
            if (frst1) nf++;
            nw++;
            @(posedge clk); #1;
        end
        checks++;
        if (nf != 2) begin errors++; $display("FAIL fifo_rst_len: high %0d cycles, need 2", nf); end
        checks++;
        if (nw != 3) begin errors++; $display("FAIL clear_ready: in_ready low %0d cycles, need 3", nw); end
        run_frame1(2, 4, 16'h0300);
    endtask

    task automatic test_unf;
        for (int c = 0; c < 4; c++) send1(16'h0400 + 16'(c), c == 0, c == 3, 1'b0);
        force_empty = 1'b1;
        drv1(1'b1, 16'h0410, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (rd1 !== 1'b0) begin errors++; $display("FAIL unf_rd_en: %0b, need 0", rd1); end
        @(posedge clk); #1;
        drv1(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        force_empty = 1'b0;
        checks++;
        if (eu1 !== 1'b1 || frst1 !== 1'b1 || rdy1 !== 1'b0) begin
            errors++; $display("FAIL err_unf: unf=%0b fifo_rst=%0b ready=%0b, need 1 1 0", eu1, frst1, rdy1);
        end
        wait_ready1("unf_recover");
    endtask

    task automatic test_rst_mid;
        for (int c = 0; c < 4; c++) send1(16'h0600 + 16'(c), c == 0, c == 3, 1'b0);
        send1(16'h0610, 1'b0, 1'b0, 1'b0);
        send1(16'h0611, 1'b0, 1'b0, 1'b0);
        drv1(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ov1 !== 1'b0 || rdy1 !== 1'b1 || busy1 !== 1'b0 || pv1 !== 1'b0 || cur1 !== 16'h0) begin
            errors++; $display("FAIL rst_mid_out: valid=%0b ready=%0b busy=%0b pv=%0b cur=%h, need 0 1 0 0 0", ov1, rdy1, busy1, pv1, cur1);
        end
        checks++;
        if ({el1, eo1, eu1, frst1} !== 4'h0 || ll1 !== 12'h0) begin
            errors++; $display("FAIL rst_mid_err: errs=%b len=%0d, need 0 0", {el1, eo1, eu1, frst1}, ll1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame1(2, 4, 16'h0700);
    endtask

    task automatic test_gaps;
        logic [31:0] mask = 32'b1011_0111_1101_1011_0110_1111_1011_0101;
        int acc_cyc [12];
        int k = 0, t = 0, n = 0;
        logic [15:0] ec, ep;
        m_cur.delete(); m_prev.delete(); m_pv.delete(); m_cyc.delete();
        while (k < 12 && t < 100) begin
            v2 = mask[t % 32];
            data2 = 16'h0100 + 16'((k / 4) * 16 + (k % 4));
            sof2 = (k == 0); eol2 = (k % 4 == 3); eof2 = (k == 11);
            #1;
            if (v2 && rdy2) begin acc_cyc[k] = cyc; k++; end
            @(posedge clk); #1;
            t++;
        end
        v2 = 0; sof2 = 0; eol2 = 0; eof2 = 0;
        while (busy2 && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (k != 12 || busy2) begin errors++; $display("FAIL gaps_progress: accepted %0d busy=%0b, need 12 0", k, busy2); end
        checks++;
        if (m_cur.size() != 12) begin errors++; $display("FAIL gaps_count: %0d outputs, need 12", m_cur.size()); end
        for (int i = 0; i < 12 && i < m_cur.size() && i < k; i++) begin
            ec = 16'h0100 + 16'((i / 4) * 16 + (i % 4));
            ep = (i >= 4) ? ec - 16'h0010 : 16'h0;
            checks++;
            if (m_cur[i] !== ec || m_prev[i] !== ep || m_pv[i] !== (i >= 4)) begin
                errors++; $display("FAIL gaps_pair %0d: cur=%h prev=%h pv=%0b, need %h %h %0b", i, m_cur[i], m_prev[i], m_pv[i], ec, ep, i >= 4);
            end
            checks++;
            if (m_cyc[i] != acc_cyc[i] + 2) begin
                errors++; $display("FAIL gaps_latency %0d: out at %0d, need %0d", i, m_cyc[i], acc_cyc[i] + 2);
            end
        end
        checks++;
        if (ll2 !== 4'd4) begin errors++; $display("FAIL gaps_line_len: %0d, need 4", ll2); end
    endtask

    task automatic test_ovf;
        int n = 0;
        for (int c = 0; c < 8; c++) begin
            v2 = 1; data2 = 16'h0800 + 16'(c); sof2 = (c == 0); eol2 = 0; eof2 = 0;
            @(posedge clk); #1;
        end
        data2 = 16'h0808; sof2 = 0;
        #1;
        checks++;
        if (full2 !== 1'b1 || wr2 !== 1'b0) begin errors++; $display("FAIL ovf_write: full=%0b wr_en=%0b, need 1 0", full2, wr2); end
        @(posedge clk); #1;
        v2 = 0;
        checks++;
        if (eo2 !== 1'b1 || frst2 !== 1'b1 || rdy2 !== 1'b0 || ov2 !== 1'b0) begin
            errors++; $display("FAIL err_ovf: ovf=%0b fifo_rst=%0b ready=%0b valid=%0b, need 1 1 0 0", eo2, frst2, rdy2, ov2);
        end
        while (!rdy2 && n < 30) begin @(posedge clk); #1; n++; end
        checks++;
        if (!rdy2 || busy2) begin errors++; $display("FAIL ovf_recover: ready=%0b busy=%0b, need 1 0", rdy2, busy2); end
    endtask

    initial begin
        #1;
        test_reset;
        test_frame;
        test_len_err;
        test_unf;
        test_gaps;
        test_ovf;
        test_rst_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
